// File: rtl/mu0_pkg.sv
// Shared constants and types for the MU0 datapath register bank.
`timescale 1ns/1ps
package mu0_pkg;
  localparam int MU0_WIDTH    = 12;
  localparam int MU0_RF_DEPTH = 8;

  typedef logic [MU0_WIDTH-1:0] mu0_word_t;
endpackage

// File: rtl/mu0_regn.sv
// Single MU0 register with load, increment and asynchronous clear.
// Load beats increment. WrapOut flags an increment of an all-ones value
// that will take effect on the coming edge.
`timescale 1ns/1ps
module mu0_regn
  import mu0_pkg::*;
#(
  parameter int WIDTH = MU0_WIDTH
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Ld,
  input  logic             Inc,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             WrapOut
);

  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] q_q;

  // Next value: load has priority over increment, otherwise hold.
  always_comb begin
    q_d = q_q;
    if (Ld) begin
      q_d = D;
    end else if (Inc) begin
      q_d = q_q + WIDTH'(1);
    end
  end

  // Storage with asynchronous clear.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign Q       = q_q;
  assign WrapOut = Inc & ~Ld & (&q_q);

endmodule

// File: rtl/mu0_regfile.sv
// MU0 register bank: DEPTH x WIDTH registers, two combinational read ports,
// one write port, one increment port and a registered Wrap pulse.
// Optional macro MU0_REGFILE_BYPASS_EN forwards write data to a read port
// addressing the register being written in the same cycle.
`timescale 1ns/1ps
module mu0_regfile
  import mu0_pkg::*;
#(
  parameter  int WIDTH = MU0_WIDTH,
  parameter  int DEPTH = MU0_RF_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             WEn,
  input  logic [AW-1:0]    WAddr,
  input  logic [WIDTH-1:0] WData,
  input  logic             IncEn,
  input  logic [AW-1:0]    IncAddr,
  input  logic [AW-1:0]    RAddrA,
  output logic [WIDTH-1:0] RDataA,
  input  logic [AW-1:0]    RAddrB,
  output logic [WIDTH-1:0] RDataB,
  output logic             Wrap
);

  logic [DEPTH-1:0] ld_vec;
  logic [DEPTH-1:0] inc_vec;
  logic [DEPTH-1:0] wrap_vec;
  logic [WIDTH-1:0] q_arr [DEPTH];
  logic             wrap_d;
  logic             wrap_q;

  // One-hot decode; an increment colliding with a write is dropped.
  always_comb begin
    ld_vec  = '0;
    inc_vec = '0;
    if (WEn) begin
      ld_vec[WAddr] = 1'b1;
    end
    if (IncEn && !(WEn && (WAddr == IncAddr))) begin
      inc_vec[IncAddr] = 1'b1;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_reg
    mu0_regn #(.WIDTH(WIDTH)) u_regn (
      .Clk     (Clk),
      .Reset   (Reset),
      .Ld      (ld_vec[i]),
      .Inc     (inc_vec[i]),
      .D       (WData),
      .Q       (q_arr[i]),
      .WrapOut (wrap_vec[i])
    );
  end

  // Read muxes, with optional same-cycle write forwarding.
  always_comb begin
    RDataA = q_arr[RAddrA];
    RDataB = q_arr[RAddrB];
`ifdef MU0_REGFILE_BYPASS_EN
    if (Reset) begin
      RDataA = '0;
      RDataB = '0;
    end else begin
      if (WEn && (RAddrA == WAddr)) RDataA = WData;
      if (WEn && (RAddrB == WAddr)) RDataB = WData;
    end
`endif
  end

  // At most one register increments per edge, so OR-reduce its wrap flag.
  always_comb begin
    wrap_d = |wrap_vec;
  end

  // Wrap pulse register, cleared asynchronously.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= wrap_d;
    end
  end

  assign Wrap = wrap_q;

endmodule

// File: doc/mu0_regfile.md
Name: mu0_regfile

Overview:
- Parametrised multi-entry register bank for the MU0 datapath, generalising the single 12-bit enable register.
- DEPTH registers of WIDTH bits each, with two asynchronous read ports, one synchronous write port and one synchronous increment port.
- The increment port supports PC/pointer-style use.
- Sits between the control unit and the ALU/memory-address mux.

Parameters:
- WIDTH, 12, data width of each register in bits (at least 2).
- DEPTH, 8, number of registers; must be a power of two and at least 2.
- AW, $clog2(DEPTH), address width; derived and not overridden by the user.

Ports:
- Clk  input  1  rising-edge clock
- Reset  input  1  asynchronous, active-high reset; clears every register
- WEn  input  1  write enable
- WAddr  input  AW  write address
- WData  input  WIDTH  write data
- IncEn  input  1  increment enable
- IncAddr  input  AW  register to increment
- RAddrA  input  AW  read address, port A
- RDataA  output  WIDTH  read data, port A
- RAddrB  input  AW  read address, port B
- RDataB  output  WIDTH  read data, port B
- Wrap  output  1  registered flag: the last increment wrapped

Behaviour:
- Reset:
  - Asserting Reset clears all registers to 0 and Wrap to 0 immediately, without waiting for a clock edge.
  - While Reset is held high, writes and increments are ignored.
  - Reset takes priority over every other input at all times, including mid-operation.
- Read:
  - Combinational, zero latency: RDataA = reg[RAddrA] and RDataB = reg[RAddrB].
  - Both ports may address the same register.
- Write: on a rising edge of Clk with WEn=1, reg[WAddr] <= WData. The new value is visible on read ports after that edge.
- Increment:
  - On a rising edge with IncEn=1, reg[IncAddr] <= reg[IncAddr] + 1, modulo 2^WIDTH.
  - An increment of all-ones wraps to 0.
- Collision: if WEn=1, IncEn=1 and WAddr==IncAddr, the write wins and the increment is discarded. Wrap <= 0 for that cycle.
- Independent ops: WEn and IncEn to different addresses both take effect on the same edge.
- Wrap:
  - Updated on every edge. Wrap <= 1 only when an increment actually took effect and the old value was all-ones; otherwise Wrap <= 0.
  - It is therefore a single-cycle pulse.
- Idle: with WEn=0 and IncEn=0, all registers hold, as does the En=0 hold behaviour of the single register.
- No X propagation: addresses are always in range because DEPTH is a power of two.

Optional Feature:
- Macro: MU0_REGFILE_BYPASS_EN.
- Defined:
  - When WEn=1 and RAddrX==WAddr, RDataX = WData combinationally, giving write-through in the same cycle.
  - Bypass applies to write data only, never to increment results.
  - Bypass is suppressed while Reset=1; RData then reads 0.
- Undefined: reads always return the stored value, and a written value appears only after the clock edge.

Decomposition:
- Package mu0_pkg:
  - localparam MU0_WIDTH=12 and MU0_RF_DEPTH=8.
  - typedef mu0_word_t (logic [MU0_WIDTH-1:0]).
- Sub-module mu0_regn, instantiated DEPTH times via generate:
  - Ports: Clk, Reset, Ld, Inc, D, Q, WrapOut.
  - Ld has priority over Inc; asynchronous clear on Reset.
- Top level contains:
  - the address decode into one-hot Ld/Inc vectors;
  - the collision masking;
  - the read muxes;
  - the optional bypass;
  - the Wrap register.

Test Plan:
- Reset=1 for 200 ns with WEn=1, WAddr=3, WData=12'hFFE -> all reads return 12'h000 and Wrap=0; nothing is loaded.
- Write 12'hABC to reg 5, then WEn=0 with WData=12'h123 -> RDataA (RAddrA=5) reads 12'hABC after the edge and holds; RDataB (RAddrB=5) matches.
- Write 12'hFFE to reg 2, then IncEn on reg 2 for two edges -> reads 12'hFFF, then 12'h000 with Wrap=1 for exactly one cycle, then Wrap=0.
- WEn=1, WAddr=1, WData=12'h055 and IncEn=1, IncAddr=1 on the same edge, reg 1 = 12'h010 -> reg 1 = 12'h055 and Wrap=0. Repeat with IncAddr=4 (reg 4 = 12'h007) -> reg 1 = 12'h055 and reg 4 = 12'h008.
- Reset asserted 25 ns after a clock edge, mid-cycle, with registers nonzero -> all outputs go to 0 before the next edge. Deassert, write 12'h3C3 to reg 7 -> reads back correctly.
- With MU0_REGFILE_BYPASS_EN: WEn=1, WAddr=6, WData=12'h5A5, RAddrA=6 before the edge -> RDataA=12'h5A5 immediately. Without the macro -> RDataA keeps the old value until the edge.
